// File: rtl/misr_compactor.sv
// Multiple-input signature register with a run controller: compacts NUM_PATTERNS
// response beats into a W-bit signature and compares the result against GOLDEN.
module misr_compactor #(
   parameter int             W            = 16,
   parameter logic [W-1:0]   POLY         = 'h002D,
   parameter logic [W-1:0]   SEED         = '0,
   parameter int             NUM_PATTERNS = 1000,
   parameter logic [W-1:0]   GOLDEN       = '0,
   localparam int            CW           = $clog2(NUM_PATTERNS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          resp_valid,
   input  logic [W-1:0]  resp,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [W-1:0]  signature,
   output logic [CW-1:0] count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_PATTERNS - 1);

   state_t         state, next_state;
   logic [W-1:0]   sig_next, sig_mixed;
   logic [CW-1:0]  count_next;
   logic           pass_next;
   logic           fb;

   assign fb        = ^(signature & POLY);
   assign sig_mixed = {fb, signature[W-1:1]} ^ resp;

   // Next-state and next-register values; everything holds unless a start or beat arrives.
   always_comb begin
      next_state = state;
      sig_next   = signature;
      count_next = count;
      pass_next  = pass;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               next_state = RUN;
               sig_next   = SEED;
               count_next = '0;
               pass_next  = 1'b0;
            end
         end
         RUN: begin
            if (resp_valid) begin
               sig_next   = sig_mixed;
               count_next = count + CW'(1);
               if (count == LAST_COUNT) begin
                  next_state = DONE;
                  pass_next  = (sig_mixed == GOLDEN);
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // busy/done are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         signature <= SEED;
         count     <= '0;
         pass      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= next_state;
         signature <= sig_next;
         count     <= count_next;
         pass      <= pass_next;
         busy      <= (next_state == RUN);
         done      <= (next_state == DONE);
      end
   end

endmodule

// File: tb/tb_misr_compactor.sv
// Directed self-checking bench for misr_compactor (W=4, POLY=0011, SEED=1, 3 patterns),
// plus a single-pattern instance for the NUM_PATTERNS=1 boundary.
module tb_misr_compactor;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       resp_valid;
   logic [3:0] resp;
   logic       busy, done, pass;
   logic [3:0] signature;
   logic [1:0] count;

   logic       reset1, start1, resp_valid1;
   logic [3:0] resp1;
   logic       busy1, done1, pass1;
   logic [3:0] signature1;
   logic [0:0] count1;

   int assert_count = 0;
   int fail_count   = 0;

   misr_compactor #(
      .W(4), .POLY(4'b0011), .SEED(4'h1), .NUM_PATTERNS(3), .GOLDEN(4'hB)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .resp_valid(resp_valid), .resp(resp),
      .busy(busy), .done(done), .pass(pass), .signature(signature), .count(count)
   );

   misr_compactor #(
      .W(4), .POLY(4'b0011), .SEED(4'h1), .NUM_PATTERNS(1), .GOLDEN(4'hB)
   ) dut1 (
      .clk(clk), .reset(reset1), .start(start1), .resp_valid(resp_valid1), .resp(resp1),
      .busy(busy1), .done(done1), .pass(pass1), .signature(signature1), .count(count1)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; outputs are sampled 1 time unit after the rising edge.
   task automatic applyStimulus(input logic st, input logic vld, input logic [3:0] r);
      start      = st;
      resp_valid = vld;
      resp       = r;
      @(posedge clk);
      #1;
      start      = 1'b0;
      resp_valid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assert_count++;
      assert (observed === expected)
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic b, input logic d, input logic p,
                             input logic [3:0] s, input logic [1:0] c);
      checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
      checkOutput({tag, ".done"}, 32'(done), 32'(d));
      checkOutput({tag, ".pass"}, 32'(pass), 32'(p));
      checkOutput({tag, ".sig"}, 32'(signature), 32'(s));
      checkOutput({tag, ".count"}, 32'(count), 32'(c));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; resp_valid = 1'b0; resp = '0;
      reset1 = 1'b1; start1 = 1'b0; resp_valid1 = 1'b0; resp1 = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkState("reset", 0, 0, 0, 4'h1, 2'd0);
      reset = 1'b0;
      reset1 = 1'b0;

      // T1 golden run
      applyStimulus(1, 0, 4'h0); checkState("t1_start", 1, 0, 0, 4'h1, 2'd0);
      applyStimulus(0, 1, 4'h1); checkState("t1_b1", 1, 0, 0, 4'h9, 2'd1);
      applyStimulus(0, 1, 4'h2); checkState("t1_b2", 1, 0, 0, 4'hE, 2'd2);
      applyStimulus(0, 1, 4'h4); checkState("t1_b3", 0, 1, 1, 4'hB, 2'd3);

      // T5 beats ignored in DONE, then restart
      applyStimulus(0, 1, 4'h7); checkState("t5_ign1", 0, 1, 1, 4'hB, 2'd3);
      applyStimulus(0, 1, 4'h3); checkState("t5_ign2", 0, 1, 1, 4'hB, 2'd3);
      applyStimulus(1, 0, 4'h0); checkState("t5_start", 1, 0, 0, 4'h1, 2'd0);
      applyStimulus(0, 1, 4'h1);
      applyStimulus(0, 1, 4'h2);
      applyStimulus(0, 1, 4'h4); checkState("t5_rerun", 0, 1, 1, 4'hB, 2'd3);

      // T2 gaps between beats
      applyStimulus(1, 0, 4'h0);
      applyStimulus(0, 1, 4'h1);
      applyStimulus(0, 0, 4'hF); checkState("t2_gap1", 1, 0, 0, 4'h9, 2'd1);
      applyStimulus(0, 1, 4'h2);
      applyStimulus(0, 0, 4'h0);
      applyStimulus(0, 0, 4'h5); checkState("t2_gap2", 1, 0, 0, 4'hE, 2'd2);
      applyStimulus(0, 1, 4'h4); checkState("t2_end", 0, 1, 1, 4'hB, 2'd3);

      // T3 mismatching final beat
      applyStimulus(1, 0, 4'h0);
      applyStimulus(0, 1, 4'h1);
      applyStimulus(0, 1, 4'h2);
      applyStimulus(0, 1, 4'h5); checkState("t3_end", 0, 1, 0, 4'hA, 2'd3);

      // T6 start pulse inside RUN is ignored
      applyStimulus(1, 0, 4'h0);
      applyStimulus(0, 1, 4'h1);
      applyStimulus(1, 0, 4'h0); checkState("t6_start", 1, 0, 0, 4'h9, 2'd1);
      applyStimulus(0, 1, 4'h2);
      applyStimulus(0, 1, 4'h4); checkState("t6_end", 0, 1, 1, 4'hB, 2'd3);

      // T4 reset mid-run
      applyStimulus(1, 0, 4'h0);
      applyStimulus(0, 1, 4'h1);
      applyStimulus(0, 1, 4'h2); checkState("t4_b2", 1, 0, 0, 4'hE, 2'd2);
      reset = 1'b1;
      applyStimulus(0, 1, 4'h4); checkState("t4_reset", 0, 0, 0, 4'h1, 2'd0);
      reset = 1'b0;
      applyStimulus(0, 1, 4'h4); checkState("t4_ign", 0, 0, 0, 4'h1, 2'd0);
      applyStimulus(0, 1, 4'h6); checkState("t4_ign2", 0, 0, 0, 4'h1, 2'd0);

      // NUM_PATTERNS=1: a single beat finishes the run
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      checkOutput("np1_busy", 32'(busy1), 32'd1);
      resp_valid1 = 1'b1; resp1 = 4'h3;
      @(posedge clk); #1;
      resp_valid1 = 1'b0;
      checkOutput("np1_sig", 32'(signature1), 32'hB);
      checkOutput("np1_done", 32'(done1), 32'd1);
      checkOutput("np1_pass", 32'(pass1), 32'd1);
      checkOutput("np1_busy_end", 32'(busy1), 32'd0);
      checkOutput("np1_count", 32'(count1), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
